// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin N:1 AXI-Stream merge; grant held from first beat to tlast.
// Latency: 2 cycles from tvalid in IDLE to m_axis_tvalid; stalls propagate combinationally m_axis_tready -> s_axis_tready.
module axis_packet_arbiter #(
  parameter int S_MSEL_WIDTH = 3,
  parameter int S_CHANNEL_NO = 2**S_MSEL_WIDTH,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [S_CHANNEL_NO-1:0][DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_CHANNEL_NO-1:0]                s_axis_tvalid,
  input  logic [S_CHANNEL_NO-1:0]                s_axis_tlast,
  output logic [S_CHANNEL_NO-1:0]                s_axis_tready,
  output logic [DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  output logic [S_MSEL_WIDTH-1:0]                m_axis_tid,
  input  logic                                   m_axis_tready
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [S_MSEL_WIDTH-1:0] grant, grant_nxt;
  logic [S_MSEL_WIDTH-1:0] last_grant, last_grant_nxt;
  logic [S_MSEL_WIDTH-1:0] cand;
  logic                    load_en;
  logic                    beat_acc;

  assign load_en  = ~m_axis_tvalid | m_axis_tready;
  assign beat_acc = (state == BUSY) & s_axis_tvalid[grant] & load_en;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    s_axis_tready  = '0;
    cand           = '0;
    case (state)
      IDLE: begin
        if (|s_axis_tvalid) begin
          // Walk from furthest to nearest so the closest requester after last_grant wins.
          for (int i = S_CHANNEL_NO; i >= 1; i--) begin
            cand = last_grant + S_MSEL_WIDTH'(i);
            if (s_axis_tvalid[cand]) grant_nxt = cand;
          end
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_axis_tready[grant] = load_en;
        if (beat_acc && s_axis_tlast[grant]) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= S_MSEL_WIDTH'(S_CHANNEL_NO - 1);
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      if (beat_acc) begin
        m_axis_tdata  <= s_axis_tdata[grant];
        m_axis_tlast  <= s_axis_tlast[grant];
        m_axis_tid    <= grant;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter: source models feed directed packets, a monitor checks merged beats.
module tb_axis_packet_arbiter;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic [7:0][31:0] s_axis_tdata;
  logic [7:0]       s_axis_tvalid;
  logic [7:0]       s_axis_tlast;
  logic [7:0]       s_axis_tready;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic [2:0]       m_axis_tid;
  logic             m_axis_tready;

  axis_packet_arbiter #(.S_MSEL_WIDTH(3), .S_CHANNEL_NO(8), .DATA_WIDTH(32)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct { logic [31:0] d; logic l; int gap; } beat_t;
  typedef struct { logic [2:0] id; logic [31:0] d; logic l; int cyc; } exp_t;

  beat_t      src_q[8][$];
  int         gap_cnt[8];
  exp_t       exp_q[$];
  logic       rdy_pat[$];
  int         checks = 0;
  int         failures = 0;
  int         beats_seen = 0;
  logic [7:0] tr_forbid = 8'h00;
  int         tr_chk_cyc = -1;
  logic [7:0] tr_chk_val = 8'h00;

  function automatic logic [31:0] mk(int t, int ch, int b);
    return 32'hA000_0000 | 32'(t << 16) | 32'(ch << 8) | 32'(b);
  endfunction

  function automatic bit src_busy();
    for (int c = 0; c < 8; c++) if (src_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 8; c++) begin
      if (src_q[c].size() > 0 && gap_cnt[c] == 0) begin
        s_axis_tvalid[c] = 1'b1;
        s_axis_tdata[c]  = src_q[c][0].d;
        s_axis_tlast[c]  = src_q[c][0].l;
      end else begin
        s_axis_tvalid[c] = 1'b0;
        s_axis_tdata[c]  = '0;
        s_axis_tlast[c]  = 1'b0;
      end
    end
  endtask

  // gap_beat: index of the beat preceded by gap_len cycles of tvalid low.
  task automatic send(int t, int ch, int n, int gap_beat, int gap_len);
    for (int b = 0; b < n; b++) begin
      beat_t x;
      x.d   = mk(t, ch, b);
      x.l   = (b == n - 1);
      x.gap = (b == gap_beat) ? gap_len : 0;
      if (src_q[ch].size() == 0) gap_cnt[ch] = x.gap;
      src_q[ch].push_back(x);
    end
    drive();
  endtask

  task automatic expect_pkt(int t, int ch, int n, int cyc0);
    for (int b = 0; b < n; b++) begin
      exp_t e;
      e.id  = 3'(ch);
      e.d   = mk(t, ch, b);
      e.l   = (b == n - 1);
      e.cyc = (cyc0 < 0) ? -1 : cyc0 + b;
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance the source models after the edge.
  task automatic step();
    logic [7:0] acc;
    @(negedge aclk);
    acc = s_axis_tvalid & s_axis_tready;
    if (!areset) begin
      check("tready_onehot", 64'($countones(s_axis_tready) <= 1), 64'd1);
      if (m_axis_tvalid && !m_axis_tready) check("tready_in_stall", 64'(s_axis_tready), 64'd0);
      if (tr_forbid != 8'h00) check("tready_forbidden", 64'(s_axis_tready & tr_forbid), 64'd0);
      if (cyc == tr_chk_cyc) check("tready_grant", 64'(s_axis_tready), 64'(tr_chk_val));
    end
    @(posedge aclk);
    #1;
    for (int c = 0; c < 8; c++) begin
      if (gap_cnt[c] > 0) gap_cnt[c]--;
      if (acc[c] && src_q[c].size() > 0) begin
        void'(src_q[c].pop_front());
        if (src_q[c].size() > 0) gap_cnt[c] = src_q[c][0].gap;
      end
    end
    m_axis_tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    drive();
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((exp_q.size() > 0 || src_busy()) && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0 || src_busy()) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
      exp_q.delete();
      for (int c = 0; c < 8; c++) src_q[c].delete();
      drive();
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      src_q[c].delete();
      gap_cnt[c] = 0;
    end
    exp_q.delete();
    rdy_pat.delete();
    tr_forbid     = 8'h00;
    m_axis_tready = 1'b1;
    drive();
    step();
    areset = 1'b0;
    @(negedge aclk);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
    check("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
    check("rst_m_tid",    64'(m_axis_tid),    64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every accepted beat, checks hold during stalls.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  logic [2:0]  prev_id;
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (prev_stall) begin
          check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
          check("hold_tdata",  64'(m_axis_tdata),  64'(prev_d));
          check("hold_tlast",  64'(m_axis_tlast),  64'(prev_l));
          check("hold_tid",    64'(m_axis_tid),    64'(prev_id));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat got tid=%0d data=%0h want no beat", m_axis_tid, m_axis_tdata);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("beat_tid",   64'(m_axis_tid),   64'(e.id));
            check("beat_tdata", 64'(m_axis_tdata), 64'(e.d));
            check("beat_tlast", 64'(m_axis_tlast), 64'(e.l));
            if (e.cyc >= 0) check("beat_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
      prev_stall = !areset && m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
      prev_id    = m_axis_tid;
    end
  end

  initial begin
    int c0;
    int n;
    int seen0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;

    // Single source: ch3, 4 beats, tready at cycle 1, output cycles 2..5.
    do_reset();
    c0 = cyc;
    tr_chk_cyc = c0 + 1;
    tr_chk_val = 8'h08;
    send(1, 3, 4, -1, 0);
    expect_pkt(1, 3, 4, c0 + 2);
    wait_drain(40);
    tr_chk_cyc = -1;

    // Round robin: all channels valid, 2-beat packets, ch0 has a second packet.
    do_reset();
    c0 = cyc;
    for (int c = 0; c < 8; c++) send(2, c, 2, -1, 0);
    send(12, 0, 2, -1, 0);
    for (int p = 0; p < 8; p++) expect_pkt(2, p, 2, c0 + 2 + 3 * p);
    expect_pkt(12, 0, 2, c0 + 2 + 3 * 8);
    wait_drain(100);

    // Backpressure on a 3-beat ch1 packet, ready pattern 1,0,0,1,1,0,1.
    do_reset();
    c0 = cyc;
    m_axis_tready = 1'b1;
    rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    send(3, 1, 3, -1, 0);
    exp_q.push_back('{id: 3'd1, d: mk(3, 1, 0), l: 1'b0, cyc: c0 + 3});
    exp_q.push_back('{id: 3'd1, d: mk(3, 1, 1), l: 1'b0, cyc: c0 + 4});
    exp_q.push_back('{id: 3'd1, d: mk(3, 1, 2), l: 1'b1, cyc: c0 + 6});
    wait_drain(40);

    // Priority wrap: after ch7, ch0 beats ch6.
    do_reset();
    send(4, 7, 1, -1, 0);
    expect_pkt(4, 7, 1, -1);
    wait_drain(40);
    send(4, 6, 2, -1, 0);
    send(4, 0, 2, -1, 0);
    expect_pkt(4, 0, 2, -1);
    expect_pkt(4, 6, 2, -1);
    wait_drain(40);

    // Source gap: ch2 drops tvalid 3 cycles before beat 2 while ch5 waits.
    do_reset();
    send(5, 2, 4, 2, 3);
    send(5, 5, 2, -1, 0);
    expect_pkt(5, 2, 4, -1);
    expect_pkt(5, 5, 2, -1);
    tr_forbid = 8'h20;
    n = 0;
    while (src_q[2].size() > 0 && n < 60) begin
      step();
      n++;
    end
    tr_forbid = 8'h00;
    wait_drain(40);

    // Reset mid-packet on a 5-beat ch4 packet, then ch0 must win over ch5.
    do_reset();
    seen0 = beats_seen;
    send(6, 4, 5, -1, 0);
    expect_pkt(6, 4, 5, -1);
    n = 0;
    while (beats_seen == seen0 && n < 40) begin
      step();
      n++;
    end
    check("midpkt_first_beat_seen", 64'(beats_seen - seen0), 64'd1);
    do_reset();
    send(7, 5, 2, -1, 0);
    send(7, 0, 2, -1, 0);
    expect_pkt(7, 0, 2, -1);
    expect_pkt(7, 5, 2, -1);
    wait_drain(40);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
